// File: rtl/bt_resp_model_pkg.sv
// bt_pkg: shared states, byte constants and message tables for the Bluetooth responder
package bt_pkg;
  typedef enum logic [2:0] {OFF, DLY, BANNER, LISTEN, RESP} state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  localparam int LINE_MAX = 15;
  localparam logic [39:0] MSG_BANNER = 40'h434d440d0a;
  localparam logic [39:0] MSG_AOK = 40'h414f4b0d0a;
  localparam logic [39:0] MSG_ERR = 40'h4552520d0a;
  function automatic logic [7:0] msg_byte(logic [39:0] m, logic [2:0] i);
    logic [39:0] s;
    s = m << (8 * i);
    return s[39:32];
  endfunction
endpackage

// File: rtl/bt_resp_model_if.sv
// bt_resp_model_if: command-link pins between the initiator and the responder
interface bt_resp_model_if;
  logic cmd_n;
  logic RX;
  logic TX;
  logic next_trk;
  logic prev_trk;
  logic [7:0] cmd_cnt;
  logic in_cmd;
  modport master(output cmd_n, RX, input TX, next_trk, prev_trk, cmd_cnt, in_cmd);
  modport slave(input cmd_n, RX, output TX, next_trk, prev_trk, cmd_cnt, in_cmd);
endinterface

// File: rtl/bt_resp_model_uart_xcvr.sv
// bt_uart_xcvr: 8N1 UART receiver and transmitter sharing one baud divider setting
module bt_uart_xcvr import bt_pkg::*; #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done
);
  rx_state_e rx_st_q;
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [3:0] tx_bit_q;
  logic [7:0] rx_sh_q;
  logic [8:0] tx_sh_q;
  logic rx_rdy_q, tx_q, busy_q, done_q;
  assign rx_data = rx_sh_q;
  assign rx_rdy = rx_rdy_q;
  assign tx_o = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  // receiver: validate start at mid-bit, then sample each bit one period later
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_rdy_q <= 1'b0;
    end else begin
      rx_rdy_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_i) rx_st_q <= RX_START;
        end
        RX_START:
          if (rx_cnt_q == 16'(BAUD_DIV / 2 - 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q <= rx_i ? RX_IDLE : RX_DATA;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        RX_DATA:
          if (rx_cnt_q == 16'(BAUD_DIV - 1)) begin
            rx_cnt_q <= '0;
            rx_sh_q <= {rx_i, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        default:
          if (rx_cnt_q == 16'(BAUD_DIV - 1)) begin
            rx_cnt_q <= '0;
            rx_rdy_q <= rx_i;
            rx_st_q <= RX_IDLE;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
      endcase
    end
  end
  // transmitter: start bit, 8 data bits LSB first, stop bit, then a one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (tx_start) begin
          busy_q <= 1'b1;
          tx_q <= 1'b0;
          tx_sh_q <= {1'b1, tx_data};
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
        end
      end else if (tx_cnt_q == 16'(BAUD_DIV - 1)) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          tx_q <= tx_sh_q[0];
          tx_sh_q <= {1'b0, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end
endmodule

// File: rtl/bt_resp_model.sv
// bt_resp_model: Bluetooth command-mode responder with banner, line parser and track decode
module bt_resp_model import bt_pkg::*; #(
  parameter int BAUD_DIV = 434,
  parameter int CMD_DLY = 1024
) (
  input logic clk,
  input logic rst,
  bt_resp_model_if.slave bus
);
  state_e state_q;
  logic [1:0] rx_sync_q, cmd_sync_q;
  logic [15:0] dly_q;
  logic [2:0] idx_q;
  logic [39:0] msg_q, resp_msg;
  logic [7:0] tx_data_q, cnt_q, rx_data;
  logic [7:0] line_q [LINE_MAX];
  logic [3:0] len_q;
  logic tx_start_q, next_q, prev_q, in_cmd_q, too_long_q;
  logic rx_rdy, tx_busy, tx_done, tx_w, is_at, cmd_s;
  assign cmd_s = cmd_sync_q[1];
  assign resp_msg = too_long_q ? MSG_ERR : MSG_AOK;
  assign is_at = len_q == 4'd3 && line_q[0] == 8'h41 && line_q[1] == 8'h54;
  assign bus.TX = tx_w;
  assign bus.next_trk = next_q;
  assign bus.prev_trk = prev_q;
  assign bus.cmd_cnt = cnt_q;
  assign bus.in_cmd = in_cmd_q;
  bt_uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk(clk), .rst(rst), .rx_i(rx_sync_q[1]), .tx_o(tx_w),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .tx_data(tx_data_q),
    .tx_start(tx_start_q), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  // two-flop synchronisers for the asynchronous pins, idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
      cmd_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], bus.RX};
      cmd_sync_q <= {cmd_sync_q[0], bus.cmd_n};
    end
  end
  // command-mode sequencer: banner, line collection, decode and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      dly_q <= '0;
      idx_q <= '0;
      msg_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q <= '0;
      in_cmd_q <= 1'b0;
      len_q <= '0;
      too_long_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
      if (cmd_s) begin
        state_q <= OFF;
        in_cmd_q <= 1'b0;
        len_q <= '0;
        too_long_q <= 1'b0;
      end else case (state_q)
        OFF: begin
          dly_q <= '0;
          state_q <= DLY;
        end
        DLY:
          if (dly_q != 16'(CMD_DLY - 1)) dly_q <= dly_q + 16'd1;
          else if (!tx_busy) begin
            state_q <= BANNER;
            msg_q <= MSG_BANNER;
            idx_q <= '0;
            tx_start_q <= 1'b1;
            tx_data_q <= msg_byte(MSG_BANNER, 3'd0);
          end
        BANNER, RESP:
          if (tx_done) begin
            if (idx_q == 3'd4) begin
              state_q <= LISTEN;
              in_cmd_q <= 1'b1;
              len_q <= '0;
              too_long_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_start_q <= 1'b1;
              tx_data_q <= msg_byte(msg_q, idx_q + 3'd1);
            end
          end
        LISTEN:
          if (rx_rdy && rx_data != LF) begin
            if (rx_data == CR) begin
              if (len_q != 4'd0) begin
                state_q <= RESP;
                idx_q <= '0;
                msg_q <= resp_msg;
                tx_start_q <= 1'b1;
                tx_data_q <= resp_msg[39:32];
                if (!too_long_q) begin
                  cnt_q <= cnt_q + 8'd1;
                  next_q <= is_at && line_q[2] == 8'h2b;
                  prev_q <= is_at && line_q[2] == 8'h2d;
                end
              end
            end else if (len_q < 4'(LINE_MAX)) begin
              line_q[len_q] <= rx_data;
              len_q <= len_q + 4'd1;
            end else too_long_q <= 1'b1;
          end
        default: state_q <= OFF;
      endcase
    end
  end
endmodule
